// File: rtl/ctx_data_bus_arbiter_pkg.sv
// ctx_bus_pkg: shared types and constants for the context/data bus arbiter.
//   src_e    : source tag that is recorded for every granted memory transaction
//   lock_e   : arbitration lock state (idle / holding a stalled request)
//   mem_req_t: request fields presented to the memory port
package ctx_bus_pkg;

   typedef enum logic [1:0] {
      SRC_CPU    = 2'd0,
      SRC_CTX_WR = 2'd1,
      SRC_CTX_RD = 2'd2
   } src_e;

   typedef enum logic {
      LK_IDLE = 1'b0,
      LK_HOLD = 1'b1
   } lock_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Context traffic is always full-word.
   localparam logic [3:0] CTX_BE = 4'hF;

endpackage

// File: rtl/ctx_data_bus_arbiter_if.sv
// ctx_data_bus_arbiter_if: bundle of the three request channels (core LSU,
// RTOSUnit ctx write, RTOSUnit ctx read) and the shared OBI-style memory port.
//   master: arbiter view (consumes requests/memory responses, drives grants,
//           memory request and routed responses)
//   slave : environment view (core, RTOSUnit and data memory)
interface ctx_data_bus_arbiter_if;

   // core data port
   logic        cpu_req_i;
   logic        cpu_gnt_o;
   logic        cpu_we_i;
   logic [3:0]  cpu_be_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_wdata_i;
   logic        cpu_rvalid_o;
   logic [31:0] cpu_rdata_o;
   // RTOSUnit context channels
   logic        ctx_wr_rdy_i;
   logic        ctx_wr_en_o;
   logic [31:0] ctx_wr_addr_i;
   logic [31:0] ctx_wr_data_i;
   logic        ctx_rd_rdy_i;
   logic        ctx_rd_en_o;
   logic [31:0] ctx_rd_addr_i;
   logic        ctx_rd_resp_en_o;
   logic [31:0] ctx_rd_resp_data_o;
   // data memory port
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   modport master (
      input  cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
      output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
      input  ctx_wr_rdy_i, ctx_wr_addr_i, ctx_wr_data_i,
      output ctx_wr_en_o,
      input  ctx_rd_rdy_i, ctx_rd_addr_i,
      output ctx_rd_en_o, ctx_rd_resp_en_o, ctx_rd_resp_data_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport slave (
      output cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
      input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
      output ctx_wr_rdy_i, ctx_wr_addr_i, ctx_wr_data_i,
      input  ctx_wr_en_o,
      output ctx_rd_rdy_i, ctx_rd_addr_i,
      input  ctx_rd_en_o, ctx_rd_resp_en_o, ctx_rd_resp_data_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

endinterface

// File: rtl/ctx_data_bus_arbiter_tag_fifo.sv
// ctx_bus_tag_fifo: in-order tag FIFO holding the source of every granted,
// not yet answered memory transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, din     : write a tag (ignored when full)
//   pop, dout     : drop the head tag (ignored when empty); dout is the head
//   full, empty   : occupancy flags
//   count         : current occupancy, 0..DEPTH
module ctx_bus_tag_fifo import ctx_bus_pkg::*; #(
   parameter int  DEPTH = 4,
   parameter type T     = src_e
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push,
   input  T                         din,
   input  logic                     pop,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/ctx_data_bus_arbiter.sv
// ctx_data_bus_arbiter: shares one OBI-style data memory port between the
// core LSU and the RTOSUnit context save/restore channels.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : request channels + memory port (master modport)
//   outstanding_o : granted-but-unanswered transactions
//   err_o         : sticky, response arrived with no transaction outstanding
// The CPU normally wins; a ctx request that has lost CTX_MAX_WAIT times in a
// row wins the next arbitration. A stalled memory request is locked until
// granted so its fields stay stable.
module ctx_data_bus_arbiter import ctx_bus_pkg::*; #(
   parameter int DEPTH        = 4,
   parameter int CTX_MAX_WAIT = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   ctx_data_bus_arbiter_if.master   bus,
   output logic [$clog2(DEPTH):0]   outstanding_o,
   output logic                     err_o
);

   localparam int WW = (CTX_MAX_WAIT > 0) ? $clog2(CTX_MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_SAT = WW'(CTX_MAX_WAIT);

   lock_e         lk_q, lk_d;
   src_e          lock_src_q, lock_src_d;
   src_e          prio_src, sel, head;
   mem_req_t      fields;
   logic [WW-1:0] wait_cnt;
   logic          any_ctx, ctx_due, req, gnt, ctx_gnt;
   logic          fifo_full, fifo_empty, pop_ok;

   // ---------------- source selection ----------------
   assign any_ctx = bus.ctx_wr_rdy_i | bus.ctx_rd_rdy_i;
   assign ctx_due = (CTX_MAX_WAIT != 0) && (wait_cnt == WAIT_SAT);

   always_comb begin
      prio_src = SRC_CPU;
      if (bus.cpu_req_i && !(ctx_due && any_ctx)) prio_src = SRC_CPU;
      else if (bus.ctx_wr_rdy_i)                  prio_src = SRC_CTX_WR;
      else if (bus.ctx_rd_rdy_i)                  prio_src = SRC_CTX_RD;
   end

   // While locked the stalled source keeps the port regardless of priority.
   assign sel = (lk_q == LK_HOLD) ? lock_src_q : prio_src;
   // No pop bypass: a full FIFO blocks the request even if a response pops now.
   assign req = (bus.cpu_req_i | any_ctx) & ~fifo_full;
   assign gnt = req & bus.mem_gnt_i;
   assign ctx_gnt = gnt & (sel != SRC_CPU);

   // ---------------- lock FSM ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lk_q       <= LK_IDLE;
         lock_src_q <= SRC_CPU;
      end else begin
         lk_q       <= lk_d;
         lock_src_q <= lock_src_d;
      end
   end

   always_comb begin
      lk_d       = lk_q;
      lock_src_d = lock_src_q;
      case (lk_q)
         LK_IDLE: if (req && !gnt) begin
            lk_d       = LK_HOLD;
            lock_src_d = sel;
         end
         LK_HOLD: if (gnt) lk_d = LK_IDLE;
         default: lk_d = LK_IDLE;
      endcase
   end

   // ---------------- starvation counter ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   wait_cnt <= '0;
      else if (!any_ctx || ctx_gnt)  wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
   end

   // ---------------- request mux ----------------
   always_comb begin
      fields = '0;
      case (sel)
         SRC_CPU: begin
            fields.we    = bus.cpu_we_i;
            fields.be    = bus.cpu_be_i;
            fields.addr  = bus.cpu_addr_i;
            fields.wdata = bus.cpu_wdata_i;
         end
         SRC_CTX_WR: begin
            fields.we    = 1'b1;
            fields.be    = CTX_BE;
            fields.addr  = bus.ctx_wr_addr_i;
            fields.wdata = bus.ctx_wr_data_i;
         end
         SRC_CTX_RD: begin
            fields.we    = 1'b0;
            fields.be    = CTX_BE;
            fields.addr  = bus.ctx_rd_addr_i;
         end
         default: fields = '0;
      endcase
   end

   // Fields are qualified by the request so the idle port reads all-zero.
   assign bus.mem_req_o   = req;
   assign bus.mem_we_o    = req & fields.we;
   assign bus.mem_be_o    = req ? fields.be    : '0;
   assign bus.mem_addr_o  = req ? fields.addr  : '0;
   assign bus.mem_wdata_o = req ? fields.wdata : '0;

   assign bus.cpu_gnt_o   = gnt & (sel == SRC_CPU);
   assign bus.ctx_wr_en_o = gnt & (sel == SRC_CTX_WR);
   assign bus.ctx_rd_en_o = gnt & (sel == SRC_CTX_RD);

   // ---------------- response routing ----------------
   ctx_bus_tag_fifo #(.DEPTH(DEPTH), .T(src_e)) u_tags (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (gnt),
      .din    (sel),
      .pop    (bus.mem_rvalid_i),
      .dout   (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (outstanding_o)
   );

   assign pop_ok = bus.mem_rvalid_i & ~fifo_empty;

   // Ctx write responses pop the tag and go nowhere.
   assign bus.cpu_rvalid_o       = pop_ok & (head == SRC_CPU);
   assign bus.ctx_rd_resp_en_o   = pop_ok & (head == SRC_CTX_RD);
   assign bus.cpu_rdata_o        = bus.mem_rdata_i;
   assign bus.ctx_rd_resp_data_o = bus.mem_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              err_o <= 1'b0;
      else if (bus.mem_rvalid_i && fifo_empty)  err_o <= 1'b1;
   end

endmodule

// File: tb/tb_ctx_data_bus_arbiter.sv
// Randomized scoreboard bench for ctx_data_bus_arbiter. The driver issues
// stimulus after each rising edge, predicts the arbiter's decision from the
// arbitration rules, and queues the expected grant and response; a monitor on
// the falling edge pops and compares whenever the DUT grants or a response
// comes back.
module tb_ctx_data_bus_arbiter;
   import ctx_bus_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXW  = 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [$clog2(DEPTH):0] outstanding;
   logic                   err;

   ctx_data_bus_arbiter_if bus ();

   ctx_data_bus_arbiter #(.DEPTH(DEPTH), .CTX_MAX_WAIT(MAXW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus           (bus),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      src_e        src;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   int n_chk = 0;
   int n_fail = 0;

   txn_t        gnt_q[$];
   txn_t        rsp_q[$];
   logic [31:0] mem_pend[$];

   // reference model state
   int   m_wait, m_out;
   bit   m_locked, m_err;
   src_e m_lock_src;
   bit   cur_req, cur_gnt, cur_rv, cur_pop, cur_any_ctx;
   txn_t cur_t;
   bit   mon_en;
   bit   cpu_done, wr_done, rd_done;
   int   p_cpu, p_wr, p_rd, p_gnt, p_rv;
   bit   force_rv;

   function automatic logic [31:0] rd_fn(logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(string name, string got, string exp);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %s expected %s at %0t", name, got, exp, $time);
   endtask

   task automatic model_reset();
      m_wait = 0; m_out = 0; m_locked = 0; m_err = 0; m_lock_src = SRC_CPU;
      cur_req = 0; cur_gnt = 0; cur_rv = 0; cur_pop = 0; cur_any_ctx = 0;
      cur_t = '{SRC_CPU, 1'b0, 4'h0, 32'h0, 32'h0};
      gnt_q.delete();
      rsp_q.delete();
   endtask

   task automatic inputs_idle();
      bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_be_i = 0;
      bus.cpu_addr_i = 0; bus.cpu_wdata_i = 0;
      bus.ctx_wr_rdy_i = 0; bus.ctx_wr_addr_i = 0; bus.ctx_wr_data_i = 0;
      bus.ctx_rd_rdy_i = 0; bus.ctx_rd_addr_i = 0;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
      cpu_done = 0; wr_done = 0; rd_done = 0;
   endtask

   task automatic knobs(int c, int w, int r, int g, int v);
      p_cpu = c; p_wr = w; p_rd = r; p_gnt = g; p_rv = v;
   endtask

   // State the arbiter should hold after the edge that ends the predicted cycle.
   task automatic model_update();
      if (cur_rv && m_out == 0) m_err = 1;
      if (cur_gnt) m_out++;
      if (cur_pop) m_out--;
      if (m_locked) begin
         if (cur_gnt) m_locked = 0;
      end else if (cur_req && !cur_gnt) begin
         m_locked   = 1;
         m_lock_src = cur_t.src;
      end
      if (!cur_any_ctx || (cur_gnt && cur_t.src != SRC_CPU)) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
   endtask

   // Agents hold a request until its grant was seen, then may issue a new one.
   task automatic drive();
      if (!bus.cpu_req_i || cpu_done) begin
         bus.cpu_req_i   = int'($urandom_range(99)) < p_cpu;
         bus.cpu_we_i    = 1'($urandom);
         bus.cpu_be_i    = 4'($urandom);
         bus.cpu_addr_i  = 32'($urandom_range(255)) << 2;
         bus.cpu_wdata_i = $urandom;
      end
      if (!bus.ctx_wr_rdy_i || wr_done) begin
         bus.ctx_wr_rdy_i  = int'($urandom_range(99)) < p_wr;
         bus.ctx_wr_addr_i = 32'h1000 | (32'($urandom_range(255)) << 2);
         bus.ctx_wr_data_i = $urandom;
      end
      if (!bus.ctx_rd_rdy_i || rd_done) begin
         bus.ctx_rd_rdy_i  = int'($urandom_range(99)) < p_rd;
         bus.ctx_rd_addr_i = 32'h2000 | (32'($urandom_range(255)) << 2);
      end
      bus.mem_gnt_i = int'($urandom_range(99)) < p_gnt;
      if (force_rv || (mem_pend.size() > 0 && int'($urandom_range(99)) < p_rv)) begin
         bus.mem_rvalid_i = 1;
         bus.mem_rdata_i  = (mem_pend.size() > 0) ? rd_fn(mem_pend.pop_front()) : 32'hBAD0_0000;
      end else begin
         bus.mem_rvalid_i = 0;
         bus.mem_rdata_i  = 0;
      end
   endtask

   // Expected behaviour for the cycle just driven, from the arbitration rules.
   task automatic predict();
      txn_t t;
      bit   starved;
      cur_any_ctx = bus.ctx_wr_rdy_i || bus.ctx_rd_rdy_i;
      starved = (MAXW != 0) && (m_wait >= MAXW);
      if (m_locked)                                      t.src = m_lock_src;
      else if (cur_any_ctx && (!bus.cpu_req_i || starved)) t.src = bus.ctx_wr_rdy_i ? SRC_CTX_WR : SRC_CTX_RD;
      else                                               t.src = SRC_CPU;
      case (t.src)
         SRC_CPU:    t = '{SRC_CPU, bus.cpu_we_i, bus.cpu_be_i, bus.cpu_addr_i, bus.cpu_wdata_i};
         SRC_CTX_WR: t = '{SRC_CTX_WR, 1'b1, 4'hF, bus.ctx_wr_addr_i, bus.ctx_wr_data_i};
         default:    t = '{SRC_CTX_RD, 1'b0, 4'hF, bus.ctx_rd_addr_i, 32'h0};
      endcase
      cur_t   = t;
      cur_req = (bus.cpu_req_i || cur_any_ctx) && (m_out < DEPTH);
      cur_gnt = cur_req && bus.mem_gnt_i;
      cur_rv  = bus.mem_rvalid_i;
      cur_pop = cur_rv && (m_out > 0);
      if (cur_gnt) begin
         gnt_q.push_back(t);
         rsp_q.push_back(t);
      end
   endtask

   task automatic step();
      @(negedge clk);
      // memory side: accept the handshake, respond later in order
      if (bus.mem_req_o && bus.mem_gnt_i) mem_pend.push_back(bus.mem_addr_o);
      cpu_done = bus.cpu_gnt_o;
      wr_done  = bus.ctx_wr_en_o;
      rd_done  = bus.ctx_rd_en_o;
      @(posedge clk);
      model_update();
      #1;
      drive();
      predict();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      txn_t e;
      if (mon_en) begin
         check("mem_req", 32'(bus.mem_req_o), 32'(cur_req));
         check("mem_addr", bus.mem_addr_o, cur_req ? cur_t.addr : 32'h0);
         if (bus.cpu_gnt_o || bus.ctx_wr_en_o || bus.ctx_rd_en_o) begin
            if (gnt_q.size() == 0) fail_evt("grant_unexpected", "grant", "none");
            else begin
               e = gnt_q.pop_front();
               check("gnt_onehot", 32'({bus.cpu_gnt_o, bus.ctx_wr_en_o, bus.ctx_rd_en_o}),
                     32'({e.src == SRC_CPU, e.src == SRC_CTX_WR, e.src == SRC_CTX_RD}));
               check("gnt_we", 32'(bus.mem_we_o), 32'(e.we));
               check("gnt_be", 32'(bus.mem_be_o), 32'(e.be));
               check("gnt_wdata", bus.mem_wdata_o, e.wdata);
            end
         end else if (gnt_q.size() != 0) begin
            fail_evt("grant_missing", "none", "grant");
            gnt_q.delete();
         end
         if (bus.mem_rvalid_i) begin
            if (rsp_q.size() == 0)
               check("stray_rsp_route", 32'({bus.cpu_rvalid_o, bus.ctx_rd_resp_en_o}), 32'h0);
            else begin
               e = rsp_q.pop_front();
               check("rsp_route", 32'({bus.cpu_rvalid_o, bus.ctx_rd_resp_en_o}),
                     32'({e.src == SRC_CPU, e.src == SRC_CTX_RD}));
               if (e.src == SRC_CPU)    check("cpu_rdata", bus.cpu_rdata_o, rd_fn(e.addr));
               if (e.src == SRC_CTX_RD) check("ctx_rdata", bus.ctx_rd_resp_data_o, rd_fn(e.addr));
            end
         end else if (bus.cpu_rvalid_o || bus.ctx_rd_resp_en_o)
            fail_evt("rsp_spurious", "response", "none");
         check("outstanding", 32'(outstanding), 32'(m_out));
         check("err", 32'(err), 32'(m_err));
      end
   end

   task automatic reset_checks(string tag);
      check({tag, "_outstanding"}, 32'(outstanding), 32'h0);
      check({tag, "_err"}, 32'(err), 32'h0);
      check({tag, "_mem_req"}, 32'(bus.mem_req_o), 32'h0);
      check({tag, "_gnts"}, 32'({bus.cpu_gnt_o, bus.ctx_wr_en_o, bus.ctx_rd_en_o}), 32'h0);
      check({tag, "_rsp"}, 32'({bus.cpu_rvalid_o, bus.ctx_rd_resp_en_o}), 32'h0);
      check({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
   endtask

   initial begin
      inputs_idle();
      model_reset();
      mon_en = 0;
      force_rv = 0;
      knobs(0, 0, 0, 0, 0);
      #2;
      reset_checks("reset");
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      mon_en = 1;

      knobs(60, 0, 0, 100, 80);  repeat (150) step();   // CPU only
      knobs(0, 60, 60, 100, 80); repeat (150) step();   // ctx only, write before read
      knobs(100, 0, 100, 100, 100); repeat (100) step(); // starvation limit
      knobs(70, 40, 40, 50, 50); repeat (1000) step();  // mixed with stalls
      knobs(80, 50, 50, 90, 5);  repeat (300) step();   // FIFO full pressure
      knobs(0, 0, 0, 100, 100);  repeat (40) step();    // drain

      // response with nothing outstanding, error must stick
      force_rv = 1; step(); force_rv = 0;
      repeat (4) step();

      // leave transactions in flight and a locked request, then reset
      knobs(100, 0, 0, 100, 0); repeat (2) step();
      knobs(100, 0, 0, 0, 0);   repeat (3) step();
      #2;
      mon_en = 0;
      rst_n = 0;
      inputs_idle();
      #1;
      reset_checks("midreset");
      model_reset();
      @(posedge clk);
      #3 rst_n = 1;
      mon_en = 1;
      // in-flight responses now arrive with nothing outstanding
      knobs(0, 0, 0, 100, 100); repeat (10) step();
      knobs(50, 30, 30, 80, 60); repeat (200) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
